// File: rtl/fifo_pkg.sv
// Shared defaults and sizing helpers for the single-clock FIFO.
package fifo_pkg;

  localparam int unsigned FifoWidth = 32;
  localparam int unsigned FifoDepth = 16;

  // Pointer width for a power-of-two depth; never narrower than one bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register array with one write port and a registered read port.
module fifo_mem #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 16,
  parameter int unsigned AddrW = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [Width-1:0] rdata_q, rdata_d;

  always_comb begin
    mem_d = mem_q;
    if (we_i) begin
      mem_d[waddr_i] = wdata_i;
    end
  end

  // Read data holds until the next accepted read.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem_q[raddr_i];
    end
  end

  // Storage is never cleared; only the read register returns to zero.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo.sv
// Synchronous single-clock FIFO: pointers, occupancy count, flag decode and accept logic.
module fifo
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH       = FifoWidth,
  parameter int unsigned DEPTH       = FifoDepth,
  parameter bit          RESET_VALUE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] input_data,
  input  logic             write,
  input  logic             read,
  output logic [WIDTH-1:0] output_data,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PtrW = ptr_width(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  logic            rst_active;
  logic            wr_en, rd_en;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  assign rst_active = (reset == RESET_VALUE);

  // Flags come only from the count register, never from the request inputs.
  assign empty = (count_q == '0);
  assign full  = (count_q == DepthCnt);

  always_comb begin
    wr_en    = write & ~full;
    rd_en    = read & ~empty;
    wr_ptr_d = wr_ptr_q + PtrW'(wr_en);
    rd_ptr_d = rd_ptr_q + PtrW'(rd_en);
    count_d  = count_q;
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_active) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  fifo_mem #(
    .Width (WIDTH),
    .Depth (DEPTH),
    .AddrW (PtrW)
  ) u_mem (
    .clk_i   (clk),
    .rst_i   (rst_active),
    .we_i    (wr_en & ~rst_active),
    .waddr_i (wr_ptr_q),
    .wdata_i (input_data),
    .re_i    (rd_en & ~rst_active),
    .raddr_i (rd_ptr_q),
    .rdata_o (output_data)
  );

endmodule

// File: tb/tb_fifo.sv
// Scoreboard bench for fifo: driver updates a queue model, monitor checks outputs after each edge.
module tb_fifo;

  localparam int unsigned Width = 32;
  localparam int unsigned Depth = 16;

  logic             clk;
  logic             reset;
  logic [Width-1:0] input_data;
  logic             write;
  logic             read;
  logic [Width-1:0] output_data;
  logic             empty;
  logic             full;

  fifo #(
    .WIDTH       (Width),
    .DEPTH       (Depth),
    .RESET_VALUE (1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .input_data  (input_data),
    .write       (write),
    .read        (read),
    .output_data (output_data),
    .empty       (empty),
    .full        (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain queue of stored words, plus the expected read-data queue.
  logic [Width-1:0] model[$];
  logic [Width-1:0] exp_q[$];
  bit               rd_fire;
  bit               rst_fire;
  int               model_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [Width-1:0] act,
                       input logic [Width-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: samples #1 after each rising edge and compares against the model.
  always @(posedge clk) begin : monitor
    bit               fire;
    bit               rf;
    int               cnt;
    logic [Width-1:0] last_out;
    logic [Width-1:0] exp_word;
    fire = rd_fire;
    rf   = rst_fire;
    cnt  = model_cnt;
    #1;
    if (rf) begin
      last_out = '0;
      check("reset_output_data", output_data, '0);
    end else if (fire) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_underflow: got a read, expected none queued");
      end else begin
        exp_word = exp_q.pop_front();
        last_out = exp_word;
        check("read_data", output_data, exp_word);
      end
    end else begin
      check("hold_data", output_data, last_out);
    end
    check("empty_flag", {31'b0, empty}, {31'b0, (cnt == 0)});
    check("full_flag", {31'b0, full}, {31'b0, (cnt == Depth)});
  end

  task automatic cycle(input bit w, input bit r, input logic [Width-1:0] d, output bit wr_ok);
    bit rd_ok;
    @(negedge clk);
    reset      = 1'b0;
    write      = w;
    read       = r;
    input_data = d;
    rd_ok = r && (model.size() > 0);
    wr_ok = w && (model.size() < Depth);
    if (rd_ok) exp_q.push_back(model.pop_front());
    if (wr_ok) model.push_back(d);
    rd_fire   = rd_ok;
    rst_fire  = 1'b0;
    model_cnt = model.size();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    write = $urandom_range(0, 1);
    read  = $urandom_range(0, 1);
    input_data = $urandom;
    model.delete();
    rd_fire   = 1'b0;
    rst_fire  = 1'b1;
    model_cnt = 0;
  endtask

  initial begin : driver
    bit               ok;
    logic [Width-1:0] next_w;
    logic [Width-1:0] pend;
    bit               have_pend;
    int               reads_done;
    int               budget;

    reset = 1'b1; write = 1'b0; read = 1'b0; input_data = '0;
    rd_fire = 1'b0; rst_fire = 1'b1; model_cnt = 0;

    // 1: reset, idle, read pulses on empty
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b0, i[0], 32'hdead_0000, ok);

    // 2: fill with 0,2,..,30, then a dropped write of 32
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 32'(2 * i), ok);
    cycle(1'b1, 1'b0, 32'd32, ok);
    cycle(1'b0, 1'b0, '0, ok);

    // 3: drain 16, then one extra read
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, '0, ok);
    cycle(1'b0, 1'b1, '0, ok);
    cycle(1'b0, 1'b0, '0, ok);

    // 4: fill 5, then 10 cycles of simultaneous read+write
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'(100 + i), ok);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 32'(200 + i), ok);

    // 5: stream 0,2,..,62 with a held producer; consumer reads only when full
    do_reset();
    next_w = '0;
    reads_done = 0;
    budget = 0;
    while (reads_done < 32 && budget < 500) begin
      bit do_rd;
      do_rd = (model.size() == Depth) || (next_w == 32'd64 && model.size() > 0);
      if (do_rd) reads_done++;
      cycle(next_w != 32'd64, do_rd, next_w, ok);
      if (ok) next_w = next_w + 32'd2;
      budget++;
    end
    n_checks++;
    if (reads_done != 32) begin
      n_fail++;
      $display("FAIL stream_budget: got %0d reads, expected 32", reads_done);
    end
    cycle(1'b0, 1'b0, '0, ok);

    // 6: reset with 7 stored, then a clean restart
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 32'(300 + i), ok);
    do_reset();
    cycle(1'b0, 1'b1, '0, ok);
    cycle(1'b1, 1'b0, 32'd77, ok);
    cycle(1'b0, 1'b1, '0, ok);
    cycle(1'b0, 1'b0, '0, ok);

    // Random traffic with a held producer and occasional reset
    have_pend = 1'b0;
    pend = '0;
    for (int i = 0; i < 600; i++) begin
      bit w, r;
      if (!have_pend && $urandom_range(0, 3) != 0) begin
        pend = $urandom;
        have_pend = 1'b1;
      end
      w = have_pend;
      r = (i < 300) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
        have_pend = 1'b0;
      end else begin
        cycle(w, r, pend, ok);
        if (ok) have_pend = 1'b0;
      end
    end
    cycle(1'b0, 1'b0, '0, ok);
    @(negedge clk);
    @(negedge clk);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
